// File: rtl/debug_cmd_decoder.sv
// debug_cmd_decoder: single-character debug command front end for the pipeline.
// Define DBG_CMD_TIMEOUT_EN to abandon a stalled 'n' count after a timeout.
`timescale 1ns/1ps
module debug_cmd_decoder #(
    parameter int DBIT      = 8,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT_W = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] rx_data,
    input  logic [31:0]     instruction_latch,
    input  logic            dump_done,
    output logic            pipe_enable,
    output logic            dump_req,
    output logic [1:0]      mode,
    output logic            halted,
    output logic            err_tick
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        CNT_HI,
        CNT_LO,
        NSTEP,
        DUMP_WAIT,
        HALTED
    } state_e;

    localparam logic [DBIT-1:0] CH_C = DBIT'(8'h63);
    localparam logic [DBIT-1:0] CH_S = DBIT'(8'h73);
    localparam logic [DBIT-1:0] CH_N = DBIT'(8'h6E);
    localparam logic [DBIT-1:0] CH_D = DBIT'(8'h64);
    localparam logic [DBIT-1:0] CH_H = DBIT'(8'h68);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DBIT-1:0] cnt_hi_q, cnt_hi_d;
    logic            pipe_enable_q, pipe_enable_d;
    logic            dump_req_q, dump_req_d;
    logic            halted_q, halted_d;
    logic            err_tick_q, err_tick_d;
    logic [1:0]      mode_q, mode_d;
    logic [CNT_W-1:0] n_load;
    logic            halt_hit;

`ifdef DBG_CMD_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo_w;
    assign unused_tmo_w = |TIMEOUT_W;
`endif

    assign n_load   = CNT_W'({cnt_hi_q, rx_data});
    assign halt_hit = pipe_enable_q && (instruction_latch == 32'hFFFF_FFFF);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cnt_hi_d      = cnt_hi_q;
        halted_d      = halted_q;
        pipe_enable_d = 1'b0;
        dump_req_d    = 1'b0;
        err_tick_d    = 1'b0;
`ifdef DBG_CMD_TIMEOUT_EN
        tmo_d         = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (rx_done_tick) begin
                    case (rx_data)
                        CH_C: begin
                            state_d       = RUN;
                            pipe_enable_d = 1'b1;
                        end
                        CH_S: begin
                            state_d       = STEP;
                            pipe_enable_d = 1'b1;
                        end
                        CH_N: state_d = CNT_HI;
                        CH_D: begin
                            state_d    = DUMP_WAIT;
                            dump_req_d = 1'b1;
                        end
                        default: err_tick_d = 1'b1;
                    endcase
                end
            end
            RUN: begin
                pipe_enable_d = 1'b1;
                if (rx_done_tick) begin
                    if (rx_data == CH_H) begin
                        pipe_enable_d = 1'b0;
                        dump_req_d    = 1'b1;
                        state_d       = DUMP_WAIT;
                    end else begin
                        err_tick_d = 1'b1;
                    end
                end
            end
            STEP: begin
                err_tick_d = rx_done_tick;
                dump_req_d = 1'b1;
                state_d    = DUMP_WAIT;
            end
            CNT_HI: begin
                if (rx_done_tick) begin
                    cnt_hi_d = rx_data;
                    state_d  = CNT_LO;
                end
            end
            CNT_LO: begin
                if (rx_done_tick) begin
                    if (n_load == '0) begin
                        dump_req_d = 1'b1;
                        state_d    = DUMP_WAIT;
                    end else begin
                        cnt_d         = n_load;
                        pipe_enable_d = 1'b1;
                        state_d       = NSTEP;
                    end
                end
            end
            NSTEP: begin
                // cnt_q counts the enable cycle in progress, so exit at one.
                err_tick_d = rx_done_tick;
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d      = '0;
                    dump_req_d = 1'b1;
                    state_d    = DUMP_WAIT;
                end else begin
                    cnt_d         = cnt_q - CNT_W'(1);
                    pipe_enable_d = 1'b1;
                end
            end
            DUMP_WAIT: begin
                err_tick_d = rx_done_tick;
                if (dump_done) begin
                    state_d = halted_q ? HALTED : IDLE;
                end
            end
            HALTED: begin
                if (rx_done_tick) begin
                    if (rx_data == CH_D) begin
                        dump_req_d = 1'b1;
                        state_d    = DUMP_WAIT;
                    end else begin
                        err_tick_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef DBG_CMD_TIMEOUT_EN
        if ((state_q == CNT_HI || state_q == CNT_LO) && !rx_done_tick) begin
            if (tmo_q == {TIMEOUT_W{1'b1}}) begin
                err_tick_d = 1'b1;
                cnt_hi_d   = '0;
                state_d    = IDLE;
            end else begin
                tmo_d = tmo_q + TIMEOUT_W'(1);
            end
        end
`endif

        // Halt wins over any step count or a same-cycle 'h'.
        if (halt_hit) begin
            pipe_enable_d = 1'b0;
            dump_req_d    = 1'b1;
            halted_d      = 1'b1;
            cnt_d         = '0;
            state_d       = DUMP_WAIT;
        end

        case (state_d)
            RUN, STEP, NSTEP: mode_d = 2'd1;
            DUMP_WAIT:        mode_d = 2'd2;
            HALTED:           mode_d = 2'd3;
            default:          mode_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cnt_hi_q      <= '0;
            pipe_enable_q <= 1'b0;
            dump_req_q    <= 1'b0;
            halted_q      <= 1'b0;
            err_tick_q    <= 1'b0;
            mode_q        <= 2'd0;
`ifdef DBG_CMD_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cnt_hi_q      <= cnt_hi_d;
            pipe_enable_q <= pipe_enable_d;
            dump_req_q    <= dump_req_d;
            halted_q      <= halted_d;
            err_tick_q    <= err_tick_d;
            mode_q        <= mode_d;
`ifdef DBG_CMD_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign pipe_enable = pipe_enable_q;
    assign dump_req    = dump_req_q;
    assign halted      = halted_q;
    assign err_tick    = err_tick_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// tb_debug_cmd_decoder: scoreboard bench, expected per-cycle outputs queued per scenario.
// Honours DBG_CMD_TIMEOUT_EN with a 4-bit timeout counter.
`timescale 1ns/1ps
module tb_debug_cmd_decoder;

    localparam int TW = 4;

    typedef struct packed {
        logic       pe;
        logic       dr;
        logic       et;
        logic       hl;
        logic [1:0] md;
    } out_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_done_tick;
    logic [7:0]  rx_data;
    logic [31:0] instruction_latch;
    logic        dump_done;
    logic        pipe_enable;
    logic        dump_req;
    logic [1:0]  mode;
    logic        halted;
    logic        err_tick;

    int   vectors = 0;
    int   miscompares = 0;
    out_t sb[$];
    out_t e, a;

    debug_cmd_decoder #(
        .DBIT      (8),
        .CNT_W     (16),
        .TIMEOUT_W (TW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_done_tick      (rx_done_tick),
        .rx_data           (rx_data),
        .instruction_latch (instruction_latch),
        .dump_done         (dump_done),
        .pipe_enable       (pipe_enable),
        .dump_req          (dump_req),
        .mode              (mode),
        .halted            (halted),
        .err_tick          (err_tick)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic pe, input logic dr, input logic et,
                                input logic hl, input logic [1:0] md);
        return {pe, dr, et, hl, md};
    endfunction

    function automatic out_t cur();
        return {pipe_enable, dump_req, err_tick, halted, mode};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
    endtask

    task automatic pulse_done();
        dump_done = 1'b1;
        tick();
        dump_done = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        reset = 1'b0;
        tick();
        tick();
        sb.push_back(mk(0, 0, 0, 0, 2'd0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL reset[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_step();
        int n = 0;
        send(8'h73);
        sb.push_back(mk(1, 0, 0, 0, 2'd1));
        sb.push_back(mk(0, 1, 0, 0, 2'd2));
        repeat (3) sb.push_back(mk(0, 0, 0, 0, 2'd2));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL step[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        pulse_done();
        sb.push_back(mk(0, 0, 0, 0, 2'd0));
        pulse_done();
        sb.push_back(mk(0, 0, 0, 0, 2'd0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL step_done[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++;
        end
    endtask

    task automatic test_nstep(input logic [7:0] hi, input logic [7:0] lo);
        int n = 0;
        int cnt = {hi, lo};
        send(8'h6E);
        send(hi);
        send(lo);
        for (int i = 0; i < cnt; i++) sb.push_back(mk(1, 0, 0, 0, 2'd1));
        sb.push_back(mk(0, 1, 0, 0, 2'd2));
        sb.push_back(mk(0, 0, 0, 0, 2'd2));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL nstep_%0d[%0d] got pe,dr,et,hl,md=%b want %b", cnt, n, a, e);
            end
            n++; tick();
        end
        pulse_done();
        e = mk(0, 0, 0, 0, 2'd0); a = cur(); vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL nstep_%0d_done got %b want %b", cnt, a, e);
        end
    endtask

    task automatic test_run();
        int n = 0;
        send(8'h63);
        repeat (20) sb.push_back(mk(1, 0, 0, 0, 2'd1));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL run[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        send(8'h78);
        sb.push_back(mk(1, 0, 1, 0, 2'd1));
        sb.push_back(mk(1, 0, 0, 0, 2'd1));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL run_err[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        send(8'h68);
        sb.push_back(mk(0, 1, 0, 0, 2'd2));
        sb.push_back(mk(0, 0, 0, 0, 2'd2));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL run_h[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        pulse_done();
        e = mk(0, 0, 0, 0, 2'd0); a = cur(); vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL run_done got %b want %b", a, e);
        end
    endtask

    task automatic test_halt();
        int n = 0;
        send(8'h63);
        repeat (9) sb.push_back(mk(1, 0, 0, 0, 2'd1));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL halt_run[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        instruction_latch = 32'hFFFF_FFFF;
        rx_data           = 8'h68;
        rx_done_tick      = 1'b1;
        tick();
        instruction_latch = 32'h0000_0013;
        rx_done_tick      = 1'b0;
        rx_data           = 8'h00;
        sb.push_back(mk(0, 1, 0, 1, 2'd2));
        sb.push_back(mk(0, 0, 0, 1, 2'd2));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL halt_hit[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        pulse_done();
        sb.push_back(mk(0, 0, 0, 1, 2'd3));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL halt_mode[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        send(8'h63);
        sb.push_back(mk(0, 0, 1, 1, 2'd3));
        sb.push_back(mk(0, 0, 0, 1, 2'd3));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL halt_c[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        send(8'h64);
        sb.push_back(mk(0, 1, 0, 1, 2'd2));
        sb.push_back(mk(0, 0, 0, 1, 2'd2));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL halt_d[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        pulse_done();
        e = mk(0, 0, 0, 1, 2'd3); a = cur(); vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL halt_redump got %b want %b", a, e);
        end
    endtask

    task automatic test_reset_mid_nstep();
        int n = 0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        send(8'h6E);
        send(8'h00);
        send(8'h64);
        repeat (40) sb.push_back(mk(1, 0, 0, 0, 2'd1));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL rst_nstep[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        e = mk(0, 0, 0, 0, 2'd0); a = cur(); vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL rst_mid got %b want %b", a, e);
        end
        test_step();
    endtask

    task automatic test_timeout();
        int n = 0;
        send(8'h6E);
        send(8'h01);
`ifdef DBG_CMD_TIMEOUT_EN
        begin
            int got = -1;
            for (int j = 1; j <= 40 && got < 0; j++) begin
                tick();
                if (err_tick) got = j;
            end
            vectors++;
            if (got != (1 << TW)) begin
                miscompares++;
                $display("FAIL timeout_cycle got %0d want %0d", got, 1 << TW);
            end
            e = mk(0, 0, 1, 0, 2'd0); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL timeout_out got %b want %b", a, e);
            end
            test_step();
        end
`else
        repeat (40) sb.push_back(mk(0, 0, 0, 0, 2'd0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL no_timeout[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        send(8'h02);
        repeat (258) sb.push_back(mk(1, 0, 0, 0, 2'd1));
        sb.push_back(mk(0, 1, 0, 0, 2'd2));
        while (sb.size() > 0) begin
            e = sb.pop_front(); a = cur(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL late_lsb[%0d] got pe,dr,et,hl,md=%b want %b", n, a, e);
            end
            n++; tick();
        end
        pulse_done();
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b0;
        rx_done_tick      = 1'b0;
        rx_data           = 8'h00;
        instruction_latch = 32'h0000_0013;
        dump_done         = 1'b0;
        tick();
        test_reset();
        test_step();
        test_nstep(8'h00, 8'h05);
        test_nstep(8'h00, 8'h00);
        test_nstep(8'h00, 8'h01);
        test_nstep(8'h01, 8'h00);
        test_run();
        test_halt();
        test_reset_mid_nstep();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
